// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a TX FIFO.
//
// Serialises words from a small FIFO onto data_tx. Each frame is one start bit, DATA_BITS data
// bits (LSB first), an optional parity bit and one or two stop bits. Baud divisor, parity mode
// and stop-bit count are sampled when a frame starts. Back-to-back frames leave no idle clock.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   baud_div     bit period = baud_div + 1 clocks
//   parity_mode  00/11 none, 01 even, 10 odd
//   two_stop     1: two stop bits, 0: one
//   break_req    (only with UART_TX_BREAK_EN) hold the line low at a frame boundary
//   in_valid     host offers in_data
//   in_ready     FIFO not full
//   in_data      word to send
//   data_tx      serial line, idle high, registered
//   active_flag  high while any frame (or break) bit is on the line
//   done_flag    one-cycle pulse in the last clock of a frame's final stop bit
//   fifo_count   words held in the FIFO
//
// Optional feature: define UART_TX_BREAK_EN to add the break_req input and break generation.

module uart_tx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 data_tx,
  output logic                 active_flag,
  output logic                 done_flag,
  output logic [CNT_WIDTH-1:0] fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned IdxW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
`ifdef UART_TX_BREAK_EN
    ,
    StBreak,
    StBreakGap
`endif
  } state_e;

  // FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;

  // Transmitter
  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 bit_end, done, try_start;

  assign in_ready   = (count_q != CNT_WIDTH'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign bit_end    = (baud_cnt_q == div_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + DIV_WIDTH'(1);
    div_d      = div_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    stop_idx_d = stop_idx_q;
    pop        = 1'b0;
    done       = 1'b0;
    try_start  = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        try_start  = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          tx_d      = shift_q[0];
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_bit_q;
            end else begin
              state_d    = StStop;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            done      = 1'b1;
            try_start = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      StBreak: begin
        baud_cnt_d = '0;
        if (!break_req) begin
          // Mandatory one-bit-period mark after a break, at the current divisor.
          state_d = StBreakGap;
          tx_d    = 1'b1;
          div_d   = baud_div;
        end
      end
      StBreakGap: begin
        if (bit_end) begin
          try_start = 1'b1;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Frame boundary: a break takes priority over queued data.
    if (try_start) begin
`ifdef UART_TX_BREAK_EN
      if (break_req) begin
        state_d    = StBreak;
        tx_d       = 1'b0;
        baud_cnt_d = '0;
      end else
`endif
      if (!fifo_empty) begin
        pop        = 1'b1;
        state_d    = StStart;
        tx_d       = 1'b0;
        baud_cnt_d = '0;
        shift_d    = head;
        div_d      = baud_div;
        par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit_d  = (^head) ^ (parity_mode == 2'b10);
        two_stop_d = two_stop;
      end else begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      tx_q       <= 1'b1;
      baud_cnt_q <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_idx_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      tx_q       <= tx_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop_idx_q <= stop_idx_d;
    end
  end

  assign data_tx     = tx_q;
  assign active_flag = (state_q != StIdle);
  assign done_flag   = done;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: an 8-bit instance and a 5-bit instance share clock, reset and config.
// Each accepted word queues its expected frame; the frame checker pops and compares per clock.

module tb_uart_tx_param;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
`ifdef UART_TX_BREAK_EN
  logic        break_req = 1'b0;
`endif

  logic       v8, r8, tx8, act8, done8;
  logic [7:0] d8;
  logic [2:0] cnt8;
  logic       v5, r5, tx5, act5, done5;
  logic [4:0] d5;
  logic [2:0] cnt5;

  always #5 clock = ~clock;

  uart_tx_param #(.DATA_BITS(8)) dut8 (
    .clock       (clock),
    .reset_n     (reset_n),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
`ifdef UART_TX_BREAK_EN
    .break_req   (break_req),
`endif
    .in_valid    (v8),
    .in_ready    (r8),
    .in_data     (d8),
    .data_tx     (tx8),
    .active_flag (act8),
    .done_flag   (done8),
    .fifo_count  (cnt8)
  );

  uart_tx_param #(.DATA_BITS(5)) dut5 (
    .clock       (clock),
    .reset_n     (reset_n),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
`ifdef UART_TX_BREAK_EN
    .break_req   (1'b0),
`endif
    .in_valid    (v5),
    .in_ready    (r5),
    .in_data     (d5),
    .data_tx     (tx5),
    .active_flag (act5),
    .done_flag   (done5),
    .fifo_count  (cnt5)
  );

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic [1:0] pmode;
    logic       two;
    int         div;
  } frame_t;

  frame_t sb_q[$];
  int total = 0;
  int bad = 0;
  int done8_seen = 0;

  always @(negedge clock) if (done8 === 1'b1) done8_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx5 : tx8;
  endfunction

  function automatic logic cur_act(input bit sel);
    return sel ? act5 : act8;
  endfunction

  function automatic logic cur_done(input bit sel);
    return sel ? done5 : done8;
  endfunction

  // Offer one word at a negedge, wait (bounded) for ready, record its expected frame.
  task automatic send_word(input bit sel, input logic [7:0] data);
    int w = 0;
    frame_t f;
    while (!(sel ? r5 : r8) && w < 400) begin
      @(negedge clock);
      w++;
    end
    chk("ready_wait", 32'(w < 400), 32'd1);
    f.data  = data;
    f.nbits = sel ? 5 : 8;
    f.pmode = parity_mode;
    f.two   = two_stop;
    f.div   = int'(baud_div);
    sb_q.push_back(f);
    if (sel) begin
      v5 = 1'b1;
      d5 = data[4:0];
    end else begin
      v8 = 1'b1;
      d8 = data;
    end
    @(negedge clock);
    v5 = 1'b0;
    v8 = 1'b0;
  endtask

  // Wait for a start bit, then compare every clock of the frame against the queued model.
  // gap = negedges waited to see the start bit (1 means no idle clock).
  task automatic check_frame(input bit sel, output int gap);
    frame_t f;
    logic   bits[$];
    logic   par;
    int     n;
    gap = 0;
    do begin
      @(negedge clock);
      gap++;
    end while (cur_tx(sel) !== 1'b0 && gap < 2000);
    chk("start_seen", 32'(gap < 2000), 32'd1);
    if (gap >= 2000) return;
    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    f = sb_q.pop_front();
    par = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < f.nbits; i++) begin
      bits.push_back(f.data[i]);
      par ^= f.data[i];
    end
    if (f.pmode == 2'b01) bits.push_back(par);
    if (f.pmode == 2'b10) bits.push_back(~par);
    bits.push_back(1'b1);
    if (f.two) bits.push_back(1'b1);
    n = bits.size();
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c <= f.div; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clock);
        chk("tx_bit", 32'(cur_tx(sel)), 32'(bits[b]));
        chk("active_in_frame", 32'(cur_act(sel)), 32'd1);
        chk("done_pulse", 32'(cur_done(sel)), 32'(b == n - 1 && c == f.div));
      end
    end
  endtask

  initial begin
    int g;
    int d0;
    baud_div    = 16'd3;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    v8 = 1'b0; d8 = '0;
    v5 = 1'b0; d5 = '0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_tx8", 32'(tx8), 32'd1);
    chk("rst_act8", 32'(act8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_cnt8", 32'(cnt8), 32'd0);
    chk("rst_rdy8", 32'(r8), 32'd1);
    chk("rst_tx5", 32'(tx5), 32'd1);
    reset_n = 1'b1;
    @(negedge clock);

    // 8N1, baud_div=3, 0xA5
    send_word(1'b0, 8'hA5);
    check_frame(1'b0, g);
    @(negedge clock);
    chk("idle_tx_a5", 32'(tx8), 32'd1);
    chk("idle_act_a5", 32'(act8), 32'd0);

    // Even then odd parity on 0x07
    baud_div    = 16'd2;
    parity_mode = 2'b01;
    send_word(1'b0, 8'h07);
    check_frame(1'b0, g);
    parity_mode = 2'b10;
    send_word(1'b0, 8'h07);
    check_frame(1'b0, g);
    @(negedge clock);
    chk("idle_act_par", 32'(act8), 32'd0);

    // Six words into a depth-4 FIFO: full at 4, frames contiguous
    parity_mode = 2'b00;
    baud_div    = 16'd3;
    d0 = done8_seen;
    fork
      begin
        send_word(1'b0, 8'h11);
        send_word(1'b0, 8'h22);
        send_word(1'b0, 8'h33);
        send_word(1'b0, 8'h44);
        send_word(1'b0, 8'h55);
        chk("full_cnt", 32'(cnt8), 32'd4);
        chk("full_rdy", 32'(r8), 32'd0);
        send_word(1'b0, 8'h66);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          check_frame(1'b0, g);
          if (i > 0) chk("no_gap", 32'(g), 32'd1);
        end
      end
    join
    @(negedge clock);
    chk("burst_done_cnt", 32'(done8_seen - d0), 32'd6);
    chk("burst_cnt0", 32'(cnt8), 32'd0);
    chk("burst_idle", 32'(act8), 32'd0);

    // 5 data bits, two stop bits, baud_div=0
    two_stop = 1'b1;
    baud_div = 16'd0;
    send_word(1'b1, 8'h1F);
    check_frame(1'b1, g);
    @(negedge clock);
    chk("idle_tx5", 32'(tx5), 32'd1);
    chk("idle_act5", 32'(act5), 32'd0);

    // Config change mid-frame must not affect the frame in flight
    two_stop = 1'b0;
    baud_div = 16'd2;
    fork
      begin
        send_word(1'b0, 8'h3C);
        repeat (4) @(negedge clock);
        baud_div    = 16'd7;
        parity_mode = 2'b01;
        two_stop    = 1'b1;
      end
      check_frame(1'b0, g);
    join
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    baud_div    = 16'd3;
    repeat (2) @(negedge clock);

    // Reset mid-DATA with words queued
    send_word(1'b0, 8'h5A);
    send_word(1'b0, 8'h77);
    send_word(1'b0, 8'h99);
    chk("pre_rst_cnt", 32'(cnt8), 32'd2);
    repeat (6) @(negedge clock);
    chk("pre_rst_act", 32'(act8), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx8), 32'd1);
    chk("async_rst_cnt", 32'(cnt8), 32'd0);
    chk("async_rst_rdy", 32'(r8), 32'd1);
    chk("async_rst_act", 32'(act8), 32'd0);
    sb_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_rst_tx", 32'(tx8), 32'd1);
    chk("post_rst_cnt", 32'(cnt8), 32'd0);

`ifdef UART_TX_BREAK_EN
    // Break: 20 clocks low, 5 clocks high at baud_div=4, then the queued frame starts
    baud_div  = 16'd4;
    break_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      chk("brk_low", 32'(tx8), 32'd0);
      chk("brk_act", 32'(act8), 32'd1);
      chk("brk_done", 32'(done8), 32'd0);
      if (i == 1) begin
        v8 = 1'b1;
        d8 = 8'hC3;
      end else begin
        v8 = 1'b0;
        chk("brk_no_pop", 32'(cnt8), 32'd1);
      end
    end
    break_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("brk_mark", 32'(tx8), 32'd1);
      chk("brk_mark_act", 32'(act8), 32'd1);
    end
    @(negedge clock);
    chk("brk_start", 32'(tx8), 32'd0);
    chk("brk_popped", 32'(cnt8), 32'd0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
